dump_ctrl: RTL and testbench
============================

Name: dump_ctrl

Overview:
- Downstream neighbour of the capture controller in the scope datapath.
- After an acquisition completes, dumps the 512-sample circular trace of one selected channel RAM, oldest sample first, to the UART transmitter one byte at a time.
- Each byte uses a send/done handshake.
- Owns the read side of the channel RAMs while a dump is active.

Parameters:
- AW, 9, RAM address width.
- DEPTH, 512, samples per channel trace; must equal 2**AW.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_dump  in  1  one-cycle request to begin a dump (honoured only in IDLE).
- dump_channel  in  2  channel select: 1=CH1, 2=CH2, 3=CH3, 0=invalid.
- trace_end  in  AW  address of the oldest sample (capture write pointer at end of acquisition); sampled at start.
- ch1_rdata  in  8  CH1 RAM read data, valid 1 cycle after ram_en.
- ch2_rdata  in  8  CH2 RAM read data, same timing as ch1_rdata.
- ch3_rdata  in  8  CH3 RAM read data, same timing as ch1_rdata.
- tx_done  in  1  UART byte-transmitted pulse.
- ram_en  out  1  RAM read enable (read-only; write enable never driven).
- ram_addr  out  AW  RAM read address.
- dump_data  out  8  byte to transmit.
- send_dump  out  1  one-cycle transmit strobe.
- dump_finished  out  1  one-cycle pulse after the last byte is acknowledged.

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE
  - ram_en=0, send_dump=0, dump_finished=0
  - ram_addr=0, dump_data=0
  - byte counter=0, latched channel=0
- States: IDLE, READ, LATCH, SEND, WAIT_TX, FINISH.
- IDLE:
  - start_dump with dump_channel!=0: latch channel; ram_addr<=trace_end; cnt<=0; go READ.
  - start_dump with dump_channel==0: go FINISH directly. No RAM read and no send_dump occur.
- READ: ram_en=1 for exactly this cycle, with ram_addr stable; go LATCH.
- LATCH: dump_data <= rdata of the latched channel; go SEND.
- SEND:
  - send_dump=1 for this single cycle; dump_data already valid and held stable until the next LATCH.
  - Go WAIT_TX.
- WAIT_TX:
  - Hold until tx_done.
  - On tx_done with cnt==DEPTH-1: go FINISH.
  - On tx_done otherwise: ram_addr<=ram_addr+1 (mod 2**AW, wraps 0x1FF->0x000); cnt<=cnt+1; go READ.
- FINISH: dump_finished=1 for one cycle; go IDLE.
- Latency:
  - start_dump to first ram_en: 1 cycle.
  - ram_en to send_dump: 2 cycles.
  - tx_done to next ram_en: 1 cycle.
  - Final tx_done to dump_finished: 1 cycle.
- Exactly DEPTH send_dump pulses per valid dump. Addresses run trace_end, trace_end+1, ..., trace_end-1 (mod 512).
- Ignored inputs:
  - start_dump outside IDLE, including during FINISH.
  - tx_done in any state other than WAIT_TX, including the SEND cycle itself.
  - trace_end and dump_channel changes after the start cycle.
- Reset asserted mid-dump: immediate return to reset values; no dump_finished pulse; the next dump starts fresh.
- Counter width AW+1 bits; no overflow possible.

Test Plan:
- Basic dump:
  - Stimulus: trace_end=0x000, dump_channel=1, CH1 RAM holds addr[7:0]; tx_done 3 cycles after each send_dump.
  - Required: 512 send_dumps with dump_data 0x00..0xFF,0x00..0xFF in order; ram_addr 0x000..0x1FF; single dump_finished one cycle after the 512th tx_done.
- Wrap-around:
  - Stimulus: trace_end=0x1F0, channel 2.
  - Required: first ram_addr 0x1F0; 0x1FF is followed by 0x000; last ram_addr 0x1EF; 512 bytes total.
- Channel select:
  - Stimulus: CH1=0x11, CH2=0x22, CH3=0x33 constant; dump channel 3.
  - Required: every dump_data=0x33.
- Invalid channel:
  - Stimulus: dump_channel=0 with start_dump.
  - Required: dump_finished one cycle later; no ram_en or send_dump ever.
- Ignored inputs:
  - Stimulus: start_dump pulsed during WAIT_TX of byte 10; tx_done pulsed in IDLE and in a SEND cycle.
  - Required: no restart, no extra byte, no skipped byte; still exactly 512 sends.
- Reset mid-dump:
  - Stimulus: rst_n low during byte 100.
  - Required: all outputs 0 immediately; no dump_finished. A new start then produces a full 512-byte dump from the new trace_end.

Source files
------------

// File: rtl/dump_ctrl.sv
// dump_ctrl: streams one channel's circular 512-sample capture trace to the
// UART transmitter, oldest sample first, one byte per send/done handshake.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start_dump      one-cycle dump request, taken only when idle
//   dump_channel    1=CH1, 2=CH2, 3=CH3, 0=invalid (finishes immediately)
//   trace_end       address of the oldest sample, sampled on the start cycle
//   ch1..3_rdata    channel RAM read data, valid the cycle after ram_en
//   tx_done         UART byte-transmitted pulse
//   ram_en/ram_addr RAM read port (read only)
//   dump_data       byte presented to the UART
//   send_dump       one-cycle transmit strobe
//   dump_finished   one-cycle pulse after the last byte is acknowledged
//
// DEPTH must equal 2**AW: the address wraps naturally at the AW-bit boundary.
module dump_ctrl #(
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_dump,
  input  logic [1:0]    dump_channel,
  input  logic [AW-1:0] trace_end,
  input  logic [7:0]    ch1_rdata,
  input  logic [7:0]    ch2_rdata,
  input  logic [7:0]    ch3_rdata,
  input  logic          tx_done,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    dump_data,
  output logic          send_dump,
  output logic          dump_finished
);

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, SEND, WAIT_TX, FINISH
  } state_t;

  state_t      state, state_nx;
  logic [AW:0] cnt;
  logic [1:0]  ch;
  logic [7:0]  sel_rdata;
  logic        last_byte;

  assign last_byte = (cnt == (AW+1)'(DEPTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_dump) state_nx = (dump_channel != 2'd0) ? READ : FINISH;
      READ:    state_nx = LATCH;
      LATCH:   state_nx = SEND;
      SEND:    state_nx = WAIT_TX;
      WAIT_TX: if (tx_done) state_nx = last_byte ? FINISH : READ;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes decode straight from state so they clear the instant reset hits.
  assign ram_en        = (state == READ);
  assign send_dump     = (state == SEND);
  assign dump_finished = (state == FINISH);

  always_comb begin
    sel_rdata = 8'h00;
    case (ch)
      2'd1:    sel_rdata = ch1_rdata;
      2'd2:    sel_rdata = ch2_rdata;
      2'd3:    sel_rdata = ch3_rdata;
      default: sel_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      dump_data <= 8'h00;
      cnt       <= '0;
      ch        <= 2'd0;
    end else begin
      case (state)
        IDLE: if (start_dump && dump_channel != 2'd0) begin
          ch       <= dump_channel;
          ram_addr <= trace_end;
          cnt      <= '0;
        end
        LATCH: dump_data <= sel_rdata;
        WAIT_TX: if (tx_done && !last_byte) begin
          ram_addr <= ram_addr + AW'(1);
          cnt      <= cnt + (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dump_ctrl.sv
module tb_dump_ctrl;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_dump = 1'b0;
  logic [1:0]    dump_channel = 2'd0;
  logic [AW-1:0] trace_end = '0;
  logic [7:0]    ch1_rdata, ch2_rdata, ch3_rdata;
  logic          tx_done = 1'b0;
  logic          ram_en, send_dump, dump_finished;
  logic [AW-1:0] ram_addr;
  logic [7:0]    dump_data;

  logic [7:0] m1 [DEPTH];
  logic [7:0] m2 [DEPTH];
  logic [7:0] m3 [DEPTH];

  int vectors = 0;
  int miscompares = 0;

  dump_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start_dump(start_dump), .dump_channel(dump_channel),
    .trace_end(trace_end), .ch1_rdata(ch1_rdata), .ch2_rdata(ch2_rdata),
    .ch3_rdata(ch3_rdata), .tx_done(tx_done), .ram_en(ram_en), .ram_addr(ram_addr),
    .dump_data(dump_data), .send_dump(send_dump), .dump_finished(dump_finished)
  );

  always #5 clk = ~clk;

  // Synchronous-read channel RAMs: data appears the cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) begin
      ch1_rdata <= m1[ram_addr];
      ch2_rdata <= m2[ram_addr];
      ch3_rdata <= m3[ram_addr];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_byte(input int ch, input int a);
    case (ch)
      1: return int'(m1[a]);
      2: return int'(m2[a]);
      3: return int'(m3[a]);
      default: return -1;
    endcase
  endfunction

  // One dump with a UART responder. fixed_dly=0 picks random 1..4 cycle
  // acknowledges; inject pulses ignored inputs; abort>0 resets mid-dump on
  // that byte's send.
  task automatic do_dump(input int te, input int ch, input int fixed_dly,
                         input int inject, input int abort);
    int nsend, nen, nfin, last_tx, en_cyc, last_addr, cd, exp_n, ea;
    bit done;
    nsend = 0; nen = 0; nfin = 0; last_tx = -1; en_cyc = -100;
    last_addr = -1; cd = -1; done = 0;
    exp_n = (ch == 0) ? 0 : DEPTH;
    @(negedge clk);
    start_dump = 1'b1; dump_channel = 2'(ch); trace_end = AW'(te);
    for (int cyc = 0; cyc < 10000 && !done; cyc++) begin
      @(negedge clk);
      start_dump = 1'b0; tx_done = 1'b0;
      dump_channel = 2'($urandom); trace_end = AW'($urandom);
      if (ram_en) begin
        nen++; last_addr = int'(ram_addr);
        if (nen == 1) chk("start_to_en", cyc, 0);
        else          chk("tx_to_en", cyc - last_tx, 1);
        en_cyc = cyc;
      end
      if (dump_finished) begin
        nfin++; done = 1;
        chk("fin_latency", cyc - last_tx, 1);
        if (inject != 0) start_dump = 1'b1;
      end else if (send_dump) begin
        ea = (te + nsend) % DEPTH;
        chk("en_to_send", cyc - en_cyc, 2);
        chk("addr", last_addr, ea);
        chk("data", int'(dump_data), exp_byte(ch, ea));
        nsend++;
        if (abort != 0 && nsend == abort) done = 1;
        else begin
          cd = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 4));
          if (inject != 0 && nsend == 10) cd = 4;
          if (inject != 0 && nsend == 5) tx_done = 1'b1;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          tx_done = 1'b1; last_tx = cyc; cd = -1;
        end else if (inject != 0 && nsend == 10 && cd == 2) begin
          start_dump = 1'b1; dump_channel = 2'd3; trace_end = AW'(7);
        end
      end
    end
    if (!done) chk("timeout", 0, 1);
    if (abort != 0) begin
      #2 rst_n = 1'b0;
      #1 chk("rst_outs_mid", int'({ram_en, send_dump, dump_finished, ram_addr, dump_data}), 0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("rst_no_fin", int'({dump_finished, ram_en, send_dump}), 0);
      end
      rst_n = 1'b1;
    end else begin
      chk("send_count", nsend, exp_n);
      chk("en_count", nen, exp_n);
      chk("fin_count", nfin, 1);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        start_dump = 1'b0;
        tx_done = (i == 2);
        chk("idle_quiet", int'({ram_en, send_dump, dump_finished}), 0);
      end
      tx_done = 1'b0;
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      m1[a] = 8'(a); m2[a] = 8'($urandom); m3[a] = 8'($urandom);
    end
    #1 chk("rst_outs", int'({ram_en, send_dump, dump_finished, ram_addr, dump_data}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic: CH1 holds addr[7:0], acknowledge 3 cycles after each send.
    do_dump(0, 1, 3, 0, 0);
    // Wrap-around from 0x1F0 on CH2.
    do_dump('h1F0, 2, 0, 0, 0);
    // Channel select with constant RAM contents.
    for (int a = 0; a < DEPTH; a++) begin
      m1[a] = 8'h11; m2[a] = 8'h22; m3[a] = 8'h33;
    end
    do_dump(int'($urandom_range(0, DEPTH-1)), 3, 0, 0, 0);
    // Invalid channel: straight to finish.
    do_dump(int'($urandom_range(0, DEPTH-1)), 0, 0, 0, 0);
    // Ignored inputs with random contents.
    for (int a = 0; a < DEPTH; a++) begin
      m1[a] = 8'($urandom); m2[a] = 8'($urandom); m3[a] = 8'($urandom);
    end
    do_dump(int'($urandom_range(0, DEPTH-1)), 1, 0, 1, 0);
    // Reset during byte 100, then a fresh full dump.
    do_dump(5, 2, 0, 0, 100);
    do_dump('h0AB, 2, 0, 0, 0);
    // Random channel and start point.
    do_dump(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(1, 3)), 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
